// File: rtl/t_inst_resp.sv
// t_inst_resp: in-order request/response buffer with sequence tagging and a
// request-side protocol checker.
//
// Accepted requests are stored with a tag and a parity bit, and returned in order
// from a DEPTH-entry FIFO. A request accepted into an empty FIFO is presented on
// the response side in the following cycle. There is no same-cycle bypass.
//
// Ports:
//   clk, rst_n         clock (posedge) and asynchronous active-low reset
//   req_valid/ready    request handshake; req_ready is registered
//   req_w5/w40/w104    request payload (5, 40, 105 bits)
//   rsp_valid/ready    response handshake
//   rsp_w5/w40/w104    head-entry payload, zero while rsp_valid is low
//   rsp_tag, rsp_par   head-entry sequence tag and XOR parity of the payload
//   level              FIFO occupancy
//   proto_err          sticky flag: a stalled request dropped or changed payload
module t_inst_resp #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_w5,
  input  logic [39:0]              req_w40,
  input  logic [104:0]             req_w104,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [4:0]               rsp_w5,
  output logic [39:0]              rsp_w40,
  output logic [104:0]             rsp_w104,
  output logic [TAGW-1:0]          rsp_tag,
  output logic                     rsp_par,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = 150;            // 5 + 40 + 105 payload bits
  localparam int unsigned EW = PW + TAGW + 1;  // {par, tag, payload}

  typedef enum logic {StIdle, StHold} chk_state_e;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [TAGW-1:0] tag_q;
  logic            req_ready_q, req_ready_d;
  logic            push, pop;
  logic [PW-1:0]   payload;
  logic [EW-1:0]   head;

  chk_state_e      state_q, state_d;
  logic [PW-1:0]   hold_q, hold_d;
  logic            proto_err_q, proto_err_d;

  assign payload   = {req_w104, req_w40, req_w5};
  assign rsp_valid = (level_q != '0);
  assign push      = req_valid & req_ready_q;
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    level_d     = level_q + LW'(push) - LW'(pop);
    // Registered ready looks at the post-edge occupancy, so a pop while full
    // re-opens the request side one cycle later.
    req_ready_d = (level_d < LW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tag_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      req_ready_q <= req_ready_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        tag_q    <= tag_q + TAGW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // response outputs are masked by rsp_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {^payload, tag_q, payload};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign rsp_w5    = rsp_valid ? head[4:0]      : '0;
  assign rsp_w40   = rsp_valid ? head[44:5]     : '0;
  assign rsp_w104  = rsp_valid ? head[149:45]   : '0;
  assign rsp_tag   = rsp_valid ? head[PW+:TAGW] : '0;
  assign rsp_par   = rsp_valid ? head[EW-1]     : 1'b0;
  assign req_ready = req_ready_q;
  assign level     = level_q;
  assign proto_err = proto_err_q;

  // Protocol checker: once a request is stalled, it must stay valid with an
  // unchanged payload until accepted.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    proto_err_d = proto_err_q;
    case (state_q)
      StIdle: begin
        if (req_valid && !req_ready_q) begin
          state_d = StHold;
          hold_d  = payload;
        end
      end
      StHold: begin
        if (!req_valid || (payload != hold_q)) begin
          proto_err_d = 1'b1;
        end
        if (!req_valid || req_ready_q) begin
          state_d = StIdle;
        end else begin
          // Still stalled: track the new payload so one change flags once.
          hold_d = payload;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_t_inst_resp.sv
module tb_t_inst_resp;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_w5;
  logic [39:0]     req_w40;
  logic [104:0]    req_w104;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_w5;
  logic [39:0]     rsp_w40;
  logic [104:0]    rsp_w104;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_par;
  logic [LW-1:0]   level;
  logic            proto_err;

  always #5 clk = ~clk;

  t_inst_resp #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_w5    (req_w5),
    .req_w40   (req_w40),
    .req_w104  (req_w104),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_w5    (rsp_w5),
    .rsp_w40   (rsp_w40),
    .rsp_w104  (rsp_w104),
    .rsp_tag   (rsp_tag),
    .rsp_par   (rsp_par),
    .level     (level),
    .proto_err (proto_err)
  );

  typedef struct packed {
    logic [4:0]      w5;
    logic [39:0]     w40;
    logic [104:0]    w104;
    logic [TAGW-1:0] tag;
    logic            par;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  exp_t            exp_q[$];
  int              m_level;
  bit              m_ready;
  bit              m_perr;
  bit              pend;
  bit              last_acc;
  logic [149:0]    pend_pl;
  logic [TAGW-1:0] m_tag;
  int              pop_cnt;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [149:0] v);
    int ones = 0;
    for (int i = 0; i < 150; i++) ones += int'(v[i]);
    return (ones % 2) == 1;
  endfunction

  function automatic logic [149:0] cur_pl();
    return {req_w104, req_w40, req_w5};
  endfunction

  // Applies the handshake rules at a clock edge, using the inputs present at the edge.
  task automatic model_update();
    bit push, pop;
    exp_t e;
    if (!rst_n) return;
    push = req_valid && m_ready;
    pop  = (m_level > 0) && rsp_ready;
    if (pend && (!req_valid || cur_pl() != pend_pl)) m_perr = 1'b1;
    pend    = req_valid && !m_ready;
    pend_pl = cur_pl();
    if (push) begin
      e.w5   = req_w5;
      e.w40  = req_w40;
      e.w104 = req_w104;
      e.tag  = m_tag;
      e.par  = par_of(cur_pl());
      exp_q.push_back(e);
      m_tag  = m_tag + 1'b1;
    end
    m_level  = m_level + int'(push) - int'(pop);
    m_ready  = (m_level < DEPTH);
    last_acc = push;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Offer a new random request unless one is stalled, which must be held.
  task automatic drive_req(input bit want);
    logic [63:0]  a;
    logic [127:0] b;
    if (req_valid && !last_acc) return;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_valid = want;
    req_w5    = 5'($urandom());
    req_w40   = a[39:0];
    req_w104  = b[104:0];
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    exp_q.delete();
    m_level  = 0;
    m_ready  = 1'b0;
    m_perr   = 1'b0;
    pend     = 1'b0;
    last_acc = 1'b0;
    pend_pl  = '0;
    m_tag    = '0;
    pop_cnt  = 0;
    #1;
    chk("rst_req_ready", 160'(req_ready), 160'(0));
    chk("rst_rsp_valid", 160'(rsp_valid), 160'(0));
    chk("rst_level", 160'(level), 160'(0));
    chk("rst_proto_err", 160'(proto_err), 160'(0));
    chk("rst_rsp_zero", 160'({rsp_w5, rsp_w40, rsp_w104, rsp_tag, rsp_par}), 160'(0));
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 160'(req_ready), 160'(0));
    step();
    chk("ready_after_edge", 160'(req_ready), 160'(1));
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("req_ready", 160'(req_ready), 160'(m_ready));
      chk("level", 160'(level), 160'(m_level));
      chk("rsp_valid", 160'(rsp_valid), 160'(m_level != 0));
      chk("proto_err", 160'(proto_err), 160'(m_perr));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 160'(rsp_valid), 160'(0));
        end else begin
          chk("rsp_head", 160'({rsp_w5, rsp_w40, rsp_w104, rsp_tag, rsp_par}), 160'(exp_q[0]));
          if (rsp_ready) begin
            pop_cnt++;
            if (pop_cnt == 257) chk("tag_wrap_257", 160'(rsp_tag), 160'(TAGW'(256)));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("rsp_zero", 160'({rsp_w5, rsp_w40, rsp_w104, rsp_tag, rsp_par}), 160'(0));
      end
    end
  end

  initial begin
    req_w5   = '0;
    req_w40  = '0;
    req_w104 = '0;
    do_reset();

    // Single transfer.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_w5    = 5'b10110;
    req_w40   = 40'h0a0b0c0d0e;
    req_w104  = {6'hf, 5'h3, 30'h12345, 64'h0abcabcd76543210};
    step();
    req_valid = 1'b0;
    chk("single_valid", 160'(rsp_valid), 160'(1));
    chk("single_tag", 160'(rsp_tag), 160'(0));
    chk("single_w40", 160'(rsp_w40), 160'(40'h0a0b0c0d0e));
    step();
    step();
    chk("single_level", 160'(level), 160'(0));

    // Fill and backpressure.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_req(1'b1);
      step();
    end
    chk("full_level", 160'(level), 160'(DEPTH));
    chk("full_ready", 160'(req_ready), 160'(0));
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_req(1'b0);
      step();
    end

    // Simultaneous push and pop at level 2.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b1);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_req(1'b1);
      step();
      chk("pp_level", 160'(level), 160'(2));
      chk("pp_valid", 160'(rsp_valid), 160'(1));
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Tag wrap.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drive_req(1'b1);
      step();
    end
    drive_req(1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("wrap_count", 160'(pop_cnt), 160'(257));

    // Protocol violation while full.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b1);
      step();
    end
    req_w40[0] = ~req_w40[0];
    step();
    chk("perr_set", 160'(proto_err), 160'(1));
    for (int i = 0; i < 30; i++) begin
      drive_req($urandom_range(0, 1) == 1);
      rsp_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    chk("perr_sticky", 160'(proto_err), 160'(1));

    // Mid-stream reset at level 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1);
      step();
    end
    req_valid = 1'b0;
    chk("mid_level", 160'(level), 160'(3));
    chk("mid_valid", 160'(rsp_valid), 160'(1));
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b1);
      step();
    end

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive_req($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_req(1'b0);
      step();
    end
    chk("drained", 160'(exp_q.size()), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
